branch_redirect_unit: RTL

//  Consumer side of branch resolution: receives taken/target outcomes from the branch exec unit,

---
 rtl/rob_pkg.sv | 38 +++
 rtl/bq_age_compare.sv | 28 ++
 rtl/branch_redirect_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared types and constants for the branch redirect unit.
//   bq_entry_t  : one branch-queue record (prediction plus resolved outcome)
//   bru_state_e : redirect FSM states
//   BQ_DEPTH_DEF / ROB_TAG_W_DEF : default geometry
//   ROB_TAG_W_MAX : width of the tag field held in an entry; the top-level
//                   ROB_TAG_W parameter must not exceed it.
// ---------------------------------------------------------------------------
package rob_pkg;

    localparam int BQ_DEPTH_DEF  = 8;
    localparam int ROB_TAG_W_DEF = 6;
    localparam int ROB_TAG_W_MAX = 16;

    typedef enum logic [1:0] {
        BRU_IDLE     = 2'd0,
        BRU_FLUSH    = 2'd1,
        BRU_REDIRECT = 2'd2
    } bru_state_e;

    typedef struct packed {
        logic                     valid;
        logic                     resolved;
        logic                     pred_taken;
        logic [63:0]              pc;
        logic [63:0]              pred_tgt;
        logic [ROB_TAG_W_MAX-1:0] rob_tag;
        logic                     act_taken;
        logic [63:0]              act_tgt;
    } bq_entry_t;

    // Sequential next PC of a not-taken branch (wraps at 2^64).
    function automatic logic [63:0] fallthrough_pc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/bq_age_compare.sv
// ---------------------------------------------------------------------------
// bq_age_compare
// Combinational older-than test between two branch-queue indices.
// Age is the distance from the current head, modulo the queue depth, so a
// smaller distance means the entry was allocated earlier.
//   head_idx_i : index part of the BQ head pointer
//   a_idx_i    : candidate index A
//   b_idx_i    : candidate index B
//   a_older_o  : 1 when A is strictly older than B
// ---------------------------------------------------------------------------
module bq_age_compare #(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] head_idx_i,
    input  logic [IDX_W-1:0] a_idx_i,
    input  logic [IDX_W-1:0] b_idx_i,
    output logic             a_older_o
);

    logic [IDX_W-1:0] a_off;
    logic [IDX_W-1:0] b_off;

    // Unsigned subtraction wraps naturally at the queue depth.
    assign a_off     = a_idx_i - head_idx_i;
    assign b_off     = b_idx_i - head_idx_i;
    assign a_older_o = (a_off < b_off);

endmodule

// File: rtl/branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit
// Holds front-end predictions in a circular branch queue, compares them with
// branch-unit outcomes, and on a mispredict issues a one-cycle ROB flush
// followed by a fetch redirect handshake. Retiring branches produce a
// predictor-training pulse one cycle later.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   alloc_*                   branch allocation from dispatch (program order)
//   alloc_ready / alloc_idx   queue has room and FSM idle / slot being written
//   res_*                     branch-unit outcome for queue slot res_idx
//   retire_valid              ROB retires the queue head
//   flush_valid/flush_rob_tag one-cycle squash of everything younger than tag
//   redirect_*                fetch redirect (valid/ready handshake)
//   train_*                   retired branch outcome for the predictor
//   bq_empty                  no live entries
//   dbg_state                 current FSM state (bru_state_e encoding)
//
// Handshake: redirect_valid rises with redirect_pc stable and stays high until
// the cycle redirect_ready is seen; only an older mispredict (which restarts
// the flush) or rst withdraws it early.
//
// Build option: define BRU_STATS_EN to add stat_resolved / stat_mispred,
// saturating counts of retired branches and latched mispredicts.
// ---------------------------------------------------------------------------
module branch_redirect_unit
    import rob_pkg::*;
#(
    parameter int BQ_DEPTH  = BQ_DEPTH_DEF,
    parameter int ROB_TAG_W = ROB_TAG_W_DEF,
    localparam int BQ_IDX_W = $clog2(BQ_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [63:0]          alloc_pc,
    input  logic                 alloc_pred_taken,
    input  logic [63:0]          alloc_pred_tgt,
    input  logic [ROB_TAG_W-1:0] alloc_rob_tag,
    output logic                 alloc_ready,
    output logic [BQ_IDX_W-1:0]  alloc_idx,
    input  logic                 res_valid,
    input  logic [BQ_IDX_W-1:0]  res_idx,
    input  logic                 res_taken,
    input  logic [63:0]          res_target,
    input  logic                 retire_valid,
    output logic                 flush_valid,
    output logic [ROB_TAG_W-1:0] flush_rob_tag,
    output logic                 redirect_valid,
    output logic [63:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic                 train_valid,
    output logic [63:0]          train_pc,
    output logic                 train_taken,
    output logic [63:0]          train_target,
    output logic [1:0]           dbg_state,
    output logic                 bq_empty
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]          stat_resolved,
    output logic [31:0]          stat_mispred
`endif
);

    localparam logic [BQ_IDX_W:0] PTR_ONE = (BQ_IDX_W+1)'(1);

    bq_entry_t              bq_q [BQ_DEPTH];
    bq_entry_t              bq_d [BQ_DEPTH];
    logic [BQ_IDX_W:0]      head_q, head_d, tail_q, tail_d;
    bru_state_e             state_q, state_d;
    logic [BQ_IDX_W-1:0]    pend_idx_q, pend_idx_d;
    logic [ROB_TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic [63:0]            redir_pc_q, redir_pc_d;
    logic                   train_valid_q, train_valid_d;
    logic [63:0]            train_pc_q, train_pc_d;
    logic                   train_taken_q, train_taken_d;
    logic [63:0]            train_target_q, train_target_d;

    logic [BQ_IDX_W-1:0]    head_idx, tail_idx, pend_off;
    logic [BQ_IDX_W:0]      flush_tail;
    logic                   full, alloc_fire;
    logic                   res_older, res_accept, res_mis;
    logic [BQ_DEPTH-1:0]    younger;

    assign head_idx   = head_q[BQ_IDX_W-1:0];
    assign tail_idx   = tail_q[BQ_IDX_W-1:0];
    assign full       = (head_idx == tail_idx) && (head_q[BQ_IDX_W] != tail_q[BQ_IDX_W]);
    assign alloc_fire = alloc_valid && alloc_ready;

    // Truncated tail keeps the mispredicted branch itself; offset is added to
    // the full head pointer so the wrap bit comes out right.
    assign pend_off   = pend_idx_q - head_idx;
    assign flush_tail = head_q + {1'b0, pend_off} + PTR_ONE;

    bq_age_compare #(.IDX_W(BQ_IDX_W)) u_res_age (
        .head_idx_i (head_idx),
        .a_idx_i    (res_idx),
        .b_idx_i    (pend_idx_q),
        .a_older_o  (res_older)
    );

    for (genvar g = 0; g < BQ_DEPTH; g++) begin : g_younger
        bq_age_compare #(.IDX_W(BQ_IDX_W)) u_age (
            .head_idx_i (head_idx),
            .a_idx_i    (pend_idx_q),
            .b_idx_i    (BQ_IDX_W'(g)),
            .a_older_o  (younger[g])
        );
    end

    // While a mispredict is pending only strictly older outcomes matter;
    // younger ones belong to the wrong path.
    assign res_accept = res_valid && bq_q[res_idx].valid &&
                        ((state_q == BRU_IDLE) || res_older);
    assign res_mis    = res_accept &&
                        ((res_taken != bq_q[res_idx].pred_taken) ||
                         (res_taken && (res_target != bq_q[res_idx].pred_tgt)));

    always_comb begin
        bq_d           = bq_q;
        head_d         = head_q;
        tail_d         = tail_q;
        state_d        = state_q;
        pend_idx_d     = pend_idx_q;
        pend_tag_d     = pend_tag_q;
        redir_pc_d     = redir_pc_q;
        train_valid_d  = 1'b0;
        train_pc_d     = train_pc_q;
        train_taken_d  = train_taken_q;
        train_target_d = train_target_q;

        if (alloc_fire) begin
            bq_d[tail_idx] = '{valid: 1'b1, resolved: 1'b0,
                               pred_taken: alloc_pred_taken, pc: alloc_pc,
                               pred_tgt: alloc_pred_tgt,
                               rob_tag: ROB_TAG_W_MAX'(alloc_rob_tag),
                               act_taken: 1'b0, act_tgt: 64'd0};
            tail_d = tail_q + PTR_ONE;
        end

        if (res_accept) begin
            bq_d[res_idx].resolved  = 1'b1;
            bq_d[res_idx].act_taken = res_taken;
            bq_d[res_idx].act_tgt   = res_target;
        end

        if (res_mis) begin
            pend_idx_d = res_idx;
            pend_tag_d = bq_q[res_idx].rob_tag[ROB_TAG_W-1:0];
            redir_pc_d = res_taken ? res_target : fallthrough_pc(bq_q[res_idx].pc);
        end

        if (retire_valid) begin
            train_valid_d           = 1'b1;
            train_pc_d              = bq_q[head_idx].pc;
            train_taken_d           = bq_q[head_idx].act_taken;
            train_target_d          = bq_q[head_idx].act_tgt;
            bq_d[head_idx].valid    = 1'b0;
            bq_d[head_idx].resolved = 1'b0;
            head_d                  = head_q + PTR_ONE;
        end

        case (state_q)
            BRU_IDLE: begin
                if (res_mis) state_d = BRU_FLUSH;
            end
            BRU_FLUSH: begin
                tail_d = flush_tail;
                for (int i = 0; i < BQ_DEPTH; i++) begin
                    if (younger[i]) begin
                        bq_d[i].valid    = 1'b0;
                        bq_d[i].resolved = 1'b0;
                    end
                end
                state_d = res_mis ? BRU_FLUSH : BRU_REDIRECT;
            end
            BRU_REDIRECT: begin
                if (res_mis)             state_d = BRU_FLUSH;
                else if (redirect_ready) state_d = BRU_IDLE;
            end
            default: state_d = BRU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BQ_DEPTH; i++) bq_q[i] <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            state_q        <= BRU_IDLE;
            pend_idx_q     <= '0;
            pend_tag_q     <= '0;
            redir_pc_q     <= '0;
            train_valid_q  <= 1'b0;
            train_pc_q     <= '0;
            train_taken_q  <= 1'b0;
            train_target_q <= '0;
        end else begin
            bq_q           <= bq_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            state_q        <= state_d;
            pend_idx_q     <= pend_idx_d;
            pend_tag_q     <= pend_tag_d;
            redir_pc_q     <= redir_pc_d;
            train_valid_q  <= train_valid_d;
            train_pc_q     <= train_pc_d;
            train_taken_q  <= train_taken_d;
            train_target_q <= train_target_d;
        end
    end

    assign alloc_ready    = !full && (state_q == BRU_IDLE);
    assign alloc_idx      = tail_idx;
    assign bq_empty       = (head_q == tail_q);
    assign flush_valid    = (state_q == BRU_FLUSH);
    assign flush_rob_tag  = flush_valid ? pend_tag_q : '0;
    assign redirect_valid = (state_q == BRU_REDIRECT);
    assign redirect_pc    = redirect_valid ? redir_pc_q : 64'd0;
    assign train_valid    = train_valid_q;
    assign train_pc       = train_pc_q;
    assign train_taken    = train_taken_q;
    assign train_target   = train_target_q;
    assign dbg_state      = state_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved_q, stat_mispred_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (retire_valid && (stat_resolved_q != '1)) stat_resolved_q <= stat_resolved_q + 32'd1;
            if (res_mis && (stat_mispred_q != '1))       stat_mispred_q  <= stat_mispred_q + 32'd1;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

    // The ROB only retires a branch whose outcome is already known.
    a_retire_resolved: assert property (@(posedge clk) disable iff (rst)
        retire_valid |-> (bq_q[head_idx].valid && bq_q[head_idx].resolved));

endmodule
